button_debounce_pulse: RTL and testbench
========================================

Name: button_debounce_pulse

Overview:
- Conditions a raw, asynchronous push-button input into clean single-cycle strobes.
- Sits directly upstream of the enable-gated D flip-flop stage and drives its enable input.
- Pipeline: synchronizer chain, then a stable-count debounce FSM, then a debounced level output plus one-cycle press and release pulses.
- press_pulse is the intended source of the downstream DFF enable, so one physical press loads data exactly once.

Parameters:
- DEBOUNCE_CYCLES, 16: number of consecutive clk cycles the synchronized input must hold a new value before it is accepted. Legal range is 1 or greater.
- SYNC_STAGES, 2: depth of the input synchronizer flop chain. Legal range is 2 or greater.
- Derived localparam CNT_W = $clog2(DEBOUNCE_CYCLES+1).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- btn_raw  input  1  raw button, asynchronous to clk, may bounce.
- btn_level  output  1  debounced button level.
- press_pulse  output  1  one-cycle strobe on an accepted 0->1 transition; feeds the DFF enable.
- release_pulse  output  1  one-cycle strobe on an accepted 1->0 transition.

Behaviour:
- Reset and interface: one clock; reset is asynchronous and active-high; the ports are named clk and reset.
- While reset is asserted, all of the following are cleared to 0: synchronizer flops, counter, btn_level, press_pulse, release_pulse. State goes to IDLE.
- Reset mid-operation aborts any count in progress. After reset deasserts, a button that is still held is treated as a new press: full latency applies and press_pulse fires.
- Synchronizer: SYNC_STAGES flops in series. The last stage is sync_in. No logic sits between the stages.
- All outputs are registered.
- FSM states:
  - IDLE (btn_level=0): if sync_in=1, go to ARM_PRESS with cnt<=0.
  - ARM_PRESS (btn_level=0):
    - sync_in=0: go to IDLE, no pulse.
    - sync_in=1 and cnt==DEBOUNCE_CYCLES-1: go to HELD, set btn_level<=1 and press_pulse<=1.
    - otherwise: cnt<=cnt+1.
  - HELD (btn_level=1): if sync_in=0, go to ARM_RELEASE with cnt<=0.
  - ARM_RELEASE (btn_level=1):
    - sync_in=1: go to HELD, no pulse.
    - sync_in=0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE, set btn_level<=0 and release_pulse<=1.
    - otherwise: cnt<=cnt+1.
- Pulse rules:
  - press_pulse and release_pulse are high for exactly one cycle per accepted transition. They are cleared on the following edge.
  - The two pulses are never high in the same cycle.
  - Neither pulse re-fires while the input stays held in its level.
- Latency: if btn_raw is stable high from before rising edge N, the FSM leaves IDLE at edge N+SYNC_STAGES. press_pulse and btn_level rise at edge N+SYNC_STAGES+DEBOUNCE_CYCLES. Release latency is symmetric.
- Glitch rejection: a synchronized excursion shorter than DEBOUNCE_CYCLES+1 cycles produces no pulse and no btn_level change. Any bounce restarts the count from 0.
- Counter bounds: cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- DEBOUNCE_CYCLES=1 boundary: a transition is accepted one edge after leaving IDLE/HELD.
- Illegal or unreachable state encodings recover to IDLE with all outputs 0.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4 unless noted):
1. Clean press: btn_raw 0->1 before edge 10 and held -> btn_level and press_pulse rise at edge 16; press_pulse low again at edge 17; release_pulse stays 0.
2. Bounce rejection: btn_raw high for 3 cycles, low 2, high 3, then low -> btn_level stays 0, no pulses. Then hold high 10 cycles -> exactly one press_pulse.
3. Clean release after a press: btn_raw 1->0 before edge 40 -> btn_level falls and release_pulse is high for one cycle at edge 46. Release glitch of 2 low cycles while HELD -> no release_pulse, btn_level stays 1.
4. Reset mid-operation: assert reset asynchronously while in ARM_PRESS with cnt=2 -> all outputs 0 immediately, without waiting for an edge. Deassert with btn_raw still high -> press_pulse after the full 6-cycle latency from the first post-reset edge.
5. Downstream integration: connect press_pulse to the DFF enable and change data each cycle. Three debounced presses -> q updates exactly 3 times, each to the data value at the pulse edge.
6. DEBOUNCE_CYCLES=1: single-cycle synchronized glitch -> no pulse. Two-cycle synchronized high -> press_pulse at edge N+3.

Source files
------------

// File: rtl/button_debounce_pulse.sv
// Push-button conditioner: synchronizer chain, stable-count debounce FSM,
// registered debounced level plus single-cycle press/release strobes.
module button_debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        ARM_PRESS   = 2'b01,
        HELD        = 2'b10,
        ARM_RELEASE = 2'b11
    } state_t;

    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic                   level_n, press_n, release_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_in;

    // Plain flop chain; no logic between stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            btn_level     <= level_n;
            press_pulse   <= press_n;
            release_pulse <= release_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        level_n   = btn_level;
        press_n   = 1'b0;
        release_n = 1'b0;
        case (state)
            IDLE: begin
                level_n = 1'b0;
                if (sync_in) begin
                    state_n = ARM_PRESS;
                    cnt_n   = '0;
                end
            end
            ARM_PRESS: begin
                level_n = 1'b0;
                if (!sync_in) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = HELD;
                    cnt_n   = '0;
                    level_n = 1'b1;
                    press_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                level_n = 1'b1;
                if (!sync_in) begin
                    state_n = ARM_RELEASE;
                    cnt_n   = '0;
                end
            end
            ARM_RELEASE: begin
                level_n = 1'b1;
                if (sync_in) begin
                    state_n = HELD;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n   = IDLE;
                    cnt_n     = '0;
                    level_n   = 1'b0;
                    release_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                level_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Scoreboard bench for button_debounce_pulse: two instances (long and
// minimal debounce) against a run-length reference model, plus a DFF load check.
module tb_button_debounce_pulse;

    localparam int SYNC = 2;
    localparam int DA   = 4;
    localparam int DB   = 1;

    logic clk = 1'b0, reset = 1'b1, btn_raw = 1'b0;
    logic lvl_a, prs_a, rel_a, lvl_b, prs_b, rel_b;

    button_debounce_pulse #(.DEBOUNCE_CYCLES(DA), .SYNC_STAGES(SYNC)) dut_a (
        .clk(clk), .reset(reset), .btn_raw(btn_raw),
        .btn_level(lvl_a), .press_pulse(prs_a), .release_pulse(rel_a));

    button_debounce_pulse #(.DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SYNC)) dut_b (
        .clk(clk), .reset(reset), .btn_raw(btn_raw),
        .btn_level(lvl_b), .press_pulse(prs_b), .release_pulse(rel_b));

    always #5 clk = ~clk;

    typedef struct packed { logic level; logic press; logic rel; } exp_t;
    typedef struct { logic [7:0] sh; logic level; int run; } mstate_t;

    exp_t    qa[$], qb[$];
    mstate_t ma, mb;
    int      checks = 0, errors = 0;
    int      press_exp_a = 0, loads = 0;

    // Downstream enable-gated DFF fed by press_pulse of instance a
    logic [7:0] data = 8'h00, q = 8'h00, pend = 8'h00;
    logic       chk_q = 1'b0;
    always @(posedge clk) begin
        if (prs_a) begin
            q     <= data;
            loads <= loads + 1;
        end
    end
    always @(posedge clk) begin
        #2;
        data = 8'($urandom);
    end

    // A new level is accepted once the synchronized input has disagreed
    // with it for d+1 consecutive samples.
    function automatic exp_t mstep(inout mstate_t m, input logic raw, input logic rst, input int d);
        exp_t e;
        logic s;
        e = '0;
        if (rst) begin
            m.sh = '0; m.level = 1'b0; m.run = 0;
            return e;
        end
        s    = m.sh[SYNC-1];
        m.sh = {m.sh[6:0], raw};
        if (s != m.level) begin
            m.run++;
            if (m.run == d + 1) begin
                m.level = s;
                m.run   = 0;
                e.press = s;
                e.rel   = !s;
            end
        end else begin
            m.run = 0;
        end
        e.level = m.level;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input logic b);
        @(posedge clk);
        qa.push_back(mstep(ma, btn_raw, reset, DA));
        qb.push_back(mstep(mb, btn_raw, reset, DB));
        #2 btn_raw = b;
    endtask

    task automatic steps(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b);
    endtask

    task automatic reset_mid(input int hold);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_rst_level_a", {31'd0, lvl_a}, 0);
        check("async_rst_press_a", {31'd0, prs_a}, 0);
        check("async_rst_level_b", {31'd0, lvl_b}, 0);
        steps(btn_raw, hold);
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    // Monitor: pops one expectation per presented output cycle
    always @(negedge clk) begin
        exp_t e;
        if (chk_q) begin
            check("dff_q", {24'd0, q}, {24'd0, pend});
            chk_q = 1'b0;
        end
        if (qa.size() > 0) begin
            e = qa.pop_front();
            check("a_level", {31'd0, lvl_a}, {31'd0, e.level});
            check("a_press", {31'd0, prs_a}, {31'd0, e.press});
            check("a_release", {31'd0, rel_a}, {31'd0, e.rel});
            if (e.press) begin
                press_exp_a++;
                pend  = data;
                chk_q = 1'b1;
            end
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            check("b_level", {31'd0, lvl_b}, {31'd0, e.level});
            check("b_press", {31'd0, prs_b}, {31'd0, e.press});
            check("b_release", {31'd0, rel_b}, {31'd0, e.rel});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 1000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        ma = '{sh: '0, level: 1'b0, run: 0};
        mb = '{sh: '0, level: 1'b0, run: 0};
        steps(1'b0, 3);
        @(negedge clk);
        check("reset_state_a", {29'd0, lvl_a, prs_a, rel_a}, 0);
        check("reset_state_b", {29'd0, lvl_b, prs_b, rel_b}, 0);
        #2 reset = 1'b0;

        // clean press, held long
        steps(1'b0, 4);
        steps(1'b1, 14);
        // clean release
        steps(1'b0, 12);
        // bounce train then a solid hold
        steps(1'b1, 3); steps(1'b0, 2); steps(1'b1, 3); steps(1'b0, 8);
        steps(1'b1, 10);
        // release glitch while held, then release
        steps(1'b0, 2); steps(1'b1, 8); steps(1'b0, 12);
        // minimal-debounce glitch and two-cycle pulse
        steps(1'b1, 1); steps(1'b0, 6); steps(1'b1, 2); steps(1'b0, 8);
        // reset while arming a press (cnt=2), button still held afterwards
        steps(1'b1, 6);
        reset_mid(2);
        steps(1'b1, 12);
        // reset while held drops btn_level without a clock
        reset_mid(1);
        steps(1'b1, 10);
        steps(1'b0, 12);

        for (int k = 0; k < 120; k++) begin
            logic b;
            b = 1'($urandom);
            steps(b, int'($urandom_range(1, 9)));
        end
        steps(1'b0, 12);
        repeat (3) @(negedge clk);
        #1;
        check("queues_drained", qa.size() + qb.size(), 0);
        check("dff_load_count", loads, press_exp_a);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
